// File: rtl/sci_bcd_decoder_pkg.sv
// Shared constants and types for the XXEY scientific-notation decoder.
// The BCD digit codes and SCI_MAX_EXP are also used by the display encoder.
package sci_bcd_decoder_pkg;

  localparam logic [3:0] BCD_0       = 4'd0;
  localparam logic [3:0] BCD_9       = 4'd9;
  localparam logic [3:0] BCD_10      = 4'hA;
  localparam logic [3:0] BCD_E       = 4'hE;
  localparam logic [3:0] SCI_MAX_EXP = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MUL,
    ST_DONE
  } dec_state_t;

  function automatic logic is_bcd(input logic [3:0] d);
    return (d >= BCD_0) && (d < BCD_10);
  endfunction

endpackage

// File: rtl/sci_bcd_decoder_if.sv
// Digit-request / result bundle between an XXEY digit source and the decoder.
interface sci_bcd_decoder_if #(
  parameter int unsigned OUT_W = 37
);
  logic             start;
  logic [3:0]       dig_tens;
  logic [3:0]       dig_ones;
  logic [3:0]       dig_e;
  logic [3:0]       dig_exp;
  logic             busy;
  logic             done;
  logic [OUT_W-1:0] value;
  logic             err;
  logic             ovf;

  modport master (
    output start, dig_tens, dig_ones, dig_e, dig_exp,
    input  busy, done, value, err, ovf
  );

  modport slave (
    input  start, dig_tens, dig_ones, dig_e, dig_exp,
    output busy, done, value, err, ovf
  );
endinterface

// File: rtl/sci_bcd_decoder_mul10_step.sv
// Combinational x10 step: (in<<3)+(in<<1) evaluated 4 bits wider than OUT_W.
// carry_out flags any nonzero bit above the OUT_W-bit result.
module mul10_step #(
  parameter int unsigned OUT_W = 37
) (
  input  logic [OUT_W-1:0] in,
  output logic [OUT_W-1:0] out,
  output logic             carry_out
);
  logic [OUT_W+3:0] wide;

  always_comb begin
    wide      = ({4'b0000, in} << 3) + ({4'b0000, in} << 1);
    out       = wide[OUT_W-1:0];
    carry_out = |wide[OUT_W+3:OUT_W];
  end
endmodule

// File: rtl/sci_bcd_decoder.sv
// Rebuilds the binary count from an XXEY display word: (tens*10+ones)*10^exp,
// applying one x10 step per clock.
module sci_bcd_decoder
  import sci_bcd_decoder_pkg::*;
#(
  parameter int unsigned OUT_W = 37
) (
  input logic               clk,
  input logic               rst,
  sci_bcd_decoder_if.slave  bus
);
  dec_state_t       state;
  logic [3:0]       tens_q, ones_q, e_q, exp_q;
  logic [3:0]       cnt;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] step_out;
  logic             step_carry;
  logic             err_q, ovf_q;
  logic [6:0]       mant;
  logic             digits_ok;

  mul10_step #(.OUT_W(OUT_W)) u_mul10 (
    .in        (acc),
    .out       (step_out),
    .carry_out (step_carry)
  );

  always_comb begin
    mant      = 7'({tens_q, 3'b000}) + 7'({tens_q, 1'b0}) + 7'(ones_q);
    digits_ok = is_bcd(tens_q) && is_bcd(ones_q) && (e_q == BCD_E) && (exp_q <= SCI_MAX_EXP);
  end

  // err/ovf accumulate in err_q/ovf_q and are published only at DONE, so the
  // visible outputs stay stable between done pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.value <= '0;
      bus.err  <= 1'b0;
      bus.ovf  <= 1'b0;
      tens_q   <= '0;
      ones_q   <= '0;
      e_q      <= '0;
      exp_q    <= '0;
      cnt      <= '0;
      acc      <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.start) begin
            tens_q   <= bus.dig_tens;
            ones_q   <= bus.dig_ones;
            e_q      <= bus.dig_e;
            exp_q    <= bus.dig_exp;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            bus.busy <= 1'b1;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (!digits_ok) begin
            acc   <= '0;
            err_q <= 1'b1;
            state <= ST_DONE;
          end else begin
            acc   <= OUT_W'(mant);
            cnt   <= exp_q;
            state <= (exp_q == 4'd0) ? ST_DONE : ST_MUL;
          end
        end
        ST_MUL: begin
          acc <= step_out;
          cnt <= cnt - 4'd1;
          if (step_carry) ovf_q <= 1'b1;
          if (cnt == 4'd1) state <= ST_DONE;
        end
        ST_DONE: begin
          bus.done  <= 1'b1;
          bus.busy  <= 1'b0;
          bus.value <= acc;
          bus.err   <= err_q;
          bus.ovf   <= ovf_q;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sci_bcd_decoder.sv
// Randomised and directed bench for sci_bcd_decoder at OUT_W=37 and OUT_W=32.
module tb_sci_bcd_decoder;
  import sci_bcd_decoder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  sci_bcd_decoder_if #(.OUT_W(37)) bus37 ();
  sci_bcd_decoder_if #(.OUT_W(32)) bus32 ();

  assign bus32.start    = bus37.start;
  assign bus32.dig_tens = bus37.dig_tens;
  assign bus32.dig_ones = bus37.dig_ones;
  assign bus32.dig_e    = bus37.dig_e;
  assign bus32.dig_exp  = bus37.dig_exp;

  sci_bcd_decoder #(.OUT_W(37)) u_dut37 (.clk(clk), .rst(rst), .bus(bus37));
  sci_bcd_decoder #(.OUT_W(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));

  // Reference: plain arithmetic on the decimal meaning of the word.
  task automatic model(input logic [3:0] t, o, e, x, input int w,
                       output logic [63:0] val, output logic err, output logic ovf);
    logic [63:0] full, mask;
    err = (t > 9) || (o > 9) || (x > 9) || (e != 4'hE);
    full = 64'(t) * 64'd10 + 64'(o);
    for (int unsigned i = 0; i < 32'(x); i++) full = full * 64'd10;
    mask = (64'd1 << w) - 64'd1;
    if (err) begin
      val = '0;
      ovf = 1'b0;
    end else begin
      val = full & mask;
      ovf = full > mask;
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or on timeout).
  task automatic run_decode(input logic [3:0] t, o, e, x, output int lat);
    bus37.dig_tens = t;
    bus37.dig_ones = o;
    bus37.dig_e    = e;
    bus37.dig_exp  = x;
    bus37.start    = 1'b1;
    @(negedge clk);
    bus37.start    = 1'b0;
    bus37.dig_tens = 4'($urandom);
    bus37.dig_ones = 4'($urandom);
    bus37.dig_e    = 4'($urandom);
    bus37.dig_exp  = 4'($urandom);
    lat = 1;
    while (bus37.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    int lat, seen;
    rst = 1'b1;
    bus37.start = 1'b0;
    bus37.dig_tens = '0; bus37.dig_ones = '0; bus37.dig_e = '0; bus37.dig_exp = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({bus37.busy, bus37.done, bus37.err, bus37.ovf, bus37.value} !== '0)
      $display("FAIL reset_state got busy=%b done=%b err=%b ovf=%b value=%0d want all 0",
               bus37.busy, bus37.done, bus37.err, bus37.ovf, bus37.value);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    bus37.dig_tens = 4'd1; bus37.dig_ones = 4'd2; bus37.dig_e = BCD_E; bus37.dig_exp = 4'd5;
    bus37.start = 1'b1;
    @(negedge clk);
    bus37.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if (bus37.busy !== 1'b0 || bus37.done !== 1'b0)
      $display("FAIL reset_mid_mul got busy=%b done=%b want 0 0", bus37.busy, bus37.done);
    else pass_cnt++;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus37.done === 1'b1) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL reset_no_done got %0d done pulses want 0", seen);
    else pass_cnt++;
    run_decode(4'd1, 4'd2, BCD_E, 4'd0, lat);
    total_cnt++;
    if (lat !== 3 || bus37.value !== 37'd12)
      $display("FAIL after_reset_decode got lat=%0d value=%0d want lat=3 value=12", lat, bus37.value);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int lat;
    run_decode(4'd4, 4'd2, BCD_E, 4'd0, lat);
    total_cnt++;
    if (lat !== 3 || bus37.value !== 37'd42 || bus37.err !== 1'b0 || bus37.ovf !== 1'b0)
      $display("FAIL basic_42 got lat=%0d value=%0d err=%b ovf=%b want 3 42 0 0",
               lat, bus37.value, bus37.err, bus37.ovf);
    else pass_cnt++;
  endtask

  task automatic test_max();
    int lat;
    logic [63:0] v32;
    logic e32, o32;
    model(4'd9, 4'd9, BCD_E, 4'd9, 32, v32, e32, o32);
    run_decode(4'd9, 4'd9, BCD_E, 4'd9, lat);
    total_cnt++;
    if (lat !== 12 || bus37.value !== 37'd99_000_000_000 || bus37.ovf !== 1'b0)
      $display("FAIL max_w37 got lat=%0d value=%0d ovf=%b want 12 99000000000 0",
               lat, bus37.value, bus37.ovf);
    else pass_cnt++;
    total_cnt++;
    if (bus32.done !== 1'b1 || bus32.ovf !== 1'b1 || bus32.value !== v32[31:0])
      $display("FAIL max_w32 got done=%b ovf=%b value=%0d want 1 1 %0d",
               bus32.done, bus32.ovf, bus32.value, v32[31:0]);
    else pass_cnt++;
  endtask

  task automatic test_err();
    logic [3:0] tt[3] = '{4'd1, 4'd1, 4'd1};
    logic [3:0] oo[3] = '{4'hA, 4'd2, 4'd2};
    logic [3:0] ee[3] = '{BCD_E, BCD_E, 4'h3};
    logic [3:0] xx[3] = '{4'd1, 4'hC, 4'd1};
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_decode(tt[i], oo[i], ee[i], xx[i], lat);
      total_cnt++;
      if (lat !== 3 || bus37.err !== 1'b1 || bus37.value !== '0 || bus37.ovf !== 1'b0)
        $display("FAIL err_case%0d got lat=%0d err=%b value=%0d ovf=%b want 3 1 0 0",
                 i, lat, bus37.err, bus37.value, bus37.ovf);
      else pass_cnt++;
    end
  endtask

  task automatic test_start_while_busy();
    int lat, dones;
    bus37.dig_tens = 4'd1; bus37.dig_ones = 4'd0; bus37.dig_e = BCD_E; bus37.dig_exp = 4'd3;
    bus37.start = 1'b1;
    lat = 0;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      lat++;
      if (bus37.done === 1'b1) dones++;
      bus37.start = bus37.busy;
    end
    bus37.start = 1'b0;
    total_cnt++;
    if (dones !== 1 || bus37.value !== 37'd10_000)
      $display("FAIL start_while_busy got dones=%0d value=%0d want 1 10000", dones, bus37.value);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat;
    logic held_ok;
    run_decode(4'd3, 4'd3, BCD_E, 4'd2, lat);
    total_cnt++;
    if (bus37.value !== 37'd3300) $display("FAIL b2b_first got %0d want 3300", bus37.value);
    else pass_cnt++;
    bus37.dig_tens = 4'd0; bus37.dig_ones = 4'd7; bus37.dig_e = BCD_E; bus37.dig_exp = 4'd1;
    bus37.start = 1'b1;
    @(negedge clk);
    bus37.start = 1'b0;
    lat = 1;
    held_ok = 1'b1;
    while (bus37.done !== 1'b1 && lat < 40) begin
      if (bus37.value !== 37'd3300) held_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    total_cnt++;
    if (!held_ok) $display("FAIL b2b_hold got changed value before done want 3300 held");
    else pass_cnt++;
    total_cnt++;
    if (lat !== 4 || bus37.value !== 37'd70)
      $display("FAIL b2b_second got lat=%0d value=%0d want 4 70", lat, bus37.value);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [3:0] t, o, e, x;
    logic [63:0] v37, v32;
    logic er37, ov37, er32, ov32;
    int lat, want_lat;
    for (int n = 0; n < 24; n++) begin
      t = 4'($urandom_range(0, 9));
      o = 4'($urandom_range(0, 9));
      x = 4'($urandom_range(0, 9));
      e = BCD_E;
      case ($urandom_range(0, 7))
        0: t = 4'($urandom_range(10, 15));
        1: x = 4'($urandom_range(10, 15));
        2: e = 4'($urandom_range(0, 13));
        3: begin t = 4'd0; o = 4'd0; end
        default: ;
      endcase
      model(t, o, e, x, 37, v37, er37, ov37);
      model(t, o, e, x, 32, v32, er32, ov32);
      want_lat = er37 ? 3 : int'(x) + 3;
      run_decode(t, o, e, x, lat);
      total_cnt++;
      if (lat !== want_lat || bus37.value !== v37[36:0] || bus37.err !== er37 || bus37.ovf !== ov37)
        $display("FAIL rand37 %0d%0dE%0d(e=%h) got lat=%0d v=%0d err=%b ovf=%b want %0d %0d %b %b",
                 t, o, x, e, lat, bus37.value, bus37.err, bus37.ovf, want_lat, v37, er37, ov37);
      else pass_cnt++;
      total_cnt++;
      if (bus32.value !== v32[31:0] || bus32.err !== er32 || bus32.ovf !== ov32)
        $display("FAIL rand32 %0d%0dE%0d(e=%h) got v=%0d err=%b ovf=%b want %0d %b %b",
                 t, o, x, e, bus32.value, bus32.err, bus32.ovf, v32[31:0], er32, ov32);
      else pass_cnt++;
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_basic();
    @(negedge clk);
    test_max();
    @(negedge clk);
    test_err();
    @(negedge clk);
    test_start_while_busy();
    test_back_to_back();
    @(negedge clk);
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
